// File: rtl/swiwf_seqdiv.sv
// swiwf_seqdiv: sequential signed fixed-point restoring divider, one quotient bit per clock
module swiwf_seqdiv #(
  parameter int WIA = 13,
  parameter int WIB = 3,
  parameter int WF  = 16
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  input  logic               start_i,
  input  logic [WIA+WF-1:0]  diva_i,
  input  logic [WIB+WF-1:0]  divb_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIA+WF-1:0]  quo_o,
  output logic               ovf_o,
  output logic               dz_o
);
  localparam int NQ   = WIA + WF;
  localparam int NB   = WIB + WF;
  localparam int ITER = WIA + 2 * WF;
  localparam int CW   = $clog2(ITER + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [ITER-1:0] dvd_q, dvd_d, mag_q, mag_d;
  logic [NB-1:0]   rem_q, rem_d, bmag_q, bmag_d, bmag_in;
  logic            sa_q, sa_d, sb_q, sb_d, dzf_q, dzf_d;
  logic            done_q, done_d, ovf_q, ovf_d, dz_q, dz_d;
  logic [NQ-1:0]   quo_q, quo_d, amag, qmax, qmin;
  logic [NB:0]     rem_sh;
  logic            ge, neg, big;
  assign qmax    = {1'b0, {(NQ-1){1'b1}}};
  assign qmin    = {1'b1, {(NQ-1){1'b0}}};
  assign amag    = diva_i[NQ-1] ? -diva_i : diva_i;
  assign bmag_in = divb_i[NB-1] ? -divb_i : divb_i;
  // the stored remainder stays below |B|, so one extra bit suffices after the shift
  assign rem_sh  = {rem_q, dvd_q[ITER-1]};
  assign ge      = rem_sh >= {1'b0, bmag_q};
  assign neg     = sa_q ^ sb_q;
  assign big     = |mag_q[ITER-1:NQ-1];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    mag_d   = mag_q;
    rem_d   = rem_q;
    bmag_d  = bmag_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dzf_d   = dzf_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: if (start_i) begin
        sa_d    = diva_i[NQ-1];
        sb_d    = divb_i[NB-1];
        bmag_d  = bmag_in;
        dvd_d   = {amag, {WF{1'b0}}};
        rem_d   = '0;
        mag_d   = '0;
        dzf_d   = divb_i == '0;
        cnt_d   = (divb_i == '0) ? '0 : CW'(ITER);
        state_d = (divb_i == '0) ? FIX : CALC;
      end
      CALC: begin
        rem_d   = ge ? NB'(rem_sh - {1'b0, bmag_q}) : rem_sh[NB-1:0];
        dvd_d   = dvd_q << 1;
        mag_d   = {mag_q[ITER-2:0], ge};
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CW'(1)) ? FIX : CALC;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        quo_d   = dzf_q ? (sa_q ? qmin : qmax) :
                  big   ? (neg ? qmin : qmax) :
                  neg   ? -mag_q[NQ-1:0] : mag_q[NQ-1:0];
        ovf_d   = !dzf_q && big;
        dz_d    = dzf_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      mag_q   <= '0;
      rem_q   <= '0;
      bmag_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dzf_q   <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      mag_q   <= mag_d;
      rem_q   <= rem_d;
      bmag_q  <= bmag_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dzf_q   <= dzf_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign quo_o  = quo_q;
  assign ovf_o  = ovf_q;
  assign dz_o   = dz_q;
endmodule

// File: tb/tb_swiwf_seqdiv.sv
// tb_swiwf_seqdiv: randomized and directed checks of swiwf_seqdiv against an arithmetic reference
module tb_swiwf_seqdiv;
  logic        clk = 1'b0, nrst = 1'b0, start = 1'b0;
  logic [28:0] diva = '0;
  logic [18:0] divb = '0;
  logic        busy_o, done_o, ovf_o, dz_o;
  logic [28:0] quo_o;
  int checks = 0, errors = 0;
  localparam logic [28:0] QMAX = 29'h0FFFFFFF;
  localparam logic [28:0] QMIN = 29'h10000000;

  swiwf_seqdiv dut (.clk_i(clk), .nrst_i(nrst), .start_i(start), .diva_i(diva), .divb_i(divb),
                    .busy_o(busy_o), .done_o(done_o), .quo_o(quo_o), .ovf_o(ovf_o), .dz_o(dz_o));

  always #5 clk = ~clk;

  // Q = A*2^WF / B with truncation toward zero, saturating on magnitude >= 2^28
  function automatic void ref_div(input longint a, input longint b,
                                  output logic [28:0] q, output logic ovf, output logic dz);
    longint qq, mag;
    logic neg;
    dz  = (b == 0);
    ovf = 1'b0;
    neg = (a < 0) != (b < 0);
    q   = '0;
    if (dz) q = (a < 0) ? QMIN : QMAX;
    else begin
      qq  = (a * 65536) / b;
      mag = (qq < 0) ? -qq : qq;
      if (mag >= (longint'(1) << 28)) begin
        ovf = 1'b1;
        q   = neg ? QMIN : QMAX;
      end else q = qq[28:0];
    end
  endfunction

  function automatic longint sx29(input logic [28:0] v);
    logic signed [28:0] s;
    s = v;
    return longint'(s);
  endfunction

  function automatic longint sx19(input logic [18:0] v);
    logic signed [18:0] s;
    s = v;
    return longint'(s);
  endfunction

  task automatic op(input logic [28:0] a, input logic [18:0] b, output int edges);
    start = 1'b1;
    diva  = a;
    divb  = b;
    @(posedge clk);
    #1 start = 1'b0;
    diva  = 29'($urandom);
    divb  = 19'($urandom);
    edges = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int e;
    nrst  = 1'b0;
    start = 1'b1;
    diva  = 29'($urandom);
    divb  = 19'($urandom);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy_o, done_o, quo_o, ovf_o, dz_o} !== 33'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b quo=%h ovf=%b dz=%b expected all 0", busy_o, done_o, quo_o, ovf_o, dz_o);
    end
    diva = 29'h30000;
    divb = 19'h18000;
    nrst = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_rise: got busy=%b done=%b expected busy=1 done=0", busy_o, done_o);
    end
    e = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        e = i;
        break;
      end
    end
    checks++;
    if (e != 46 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_latency: got done edge %0d busy=%b expected edge 46 busy=0", e, busy_o);
    end
    checks++;
    if (quo_o !== 29'h20000 || ovf_o !== 1'b0 || dz_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_div: got quo=%h ovf=%b dz=%b expected quo=20000 ovf=0 dz=0", quo_o, ovf_o, dz_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done_o !== 1'b0 || quo_o !== 29'h20000) begin
      errors++;
      $display("FAIL done_pulse_hold: got done=%b quo=%h expected done=0 quo=20000", done_o, quo_o);
    end
  endtask

  task automatic test_signed;
    longint ta[3] = '{-65536, 65536, -131072};
    longint tb[3] = '{196608, -196608, -65536};
    longint tq[3] = '{-21845, -21845, 131072};
    logic signed [28:0] ra;
    logic signed [18:0] rb;
    logic [28:0] eq, lq;
    logic eo, ed;
    int e;
    for (int k = 0; k < 3; k++) begin
      lq = tq[k][28:0];
      op(ta[k][28:0], tb[k][18:0], e);
      checks++;
      if (e != 46 || quo_o !== lq || ovf_o !== 1'b0 || dz_o !== 1'b0) begin
        errors++;
        $display("FAIL signed_%0d: got edge %0d quo=%h ovf=%b dz=%b expected edge 46 quo=%h ovf=0 dz=0", k, e, quo_o, ovf_o, dz_o, lq);
      end
    end
    for (int k = 0; k < 24; k++) begin
      ra = 29'($urandom);
      ra = ra >>> $urandom_range(0, 28);
      rb = 19'($urandom);
      rb = rb >>> $urandom_range(0, 18);
      if (rb == 0) rb = 19'sd1;
      ref_div(sx29(ra), sx19(rb), eq, eo, ed);
      op(ra, rb, e);
      checks++;
      if (e != 46 || quo_o !== eq || ovf_o !== eo || dz_o !== ed) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h: got edge %0d quo=%h ovf=%b dz=%b expected edge 46 quo=%h ovf=%b dz=%b", k, ra, rb, e, quo_o, ovf_o, dz_o, eq, eo, ed);
      end
    end
  endtask

  task automatic test_overflow;
    logic [28:0] ta[3] = '{29'h0FFF0000, 29'h10000000, 29'h10000000};
    logic [18:0] tb[3] = '{19'h00001, 19'h70000, 19'h10000};
    logic [28:0] tq[3] = '{QMAX, QMAX, QMIN};
    int e;
    for (int k = 0; k < 3; k++) begin
      op(ta[k], tb[k], e);
      checks++;
      if (e != 46 || quo_o !== tq[k] || ovf_o !== 1'b1 || dz_o !== 1'b0) begin
        errors++;
        $display("FAIL overflow_%0d: got edge %0d quo=%h ovf=%b dz=%b expected edge 46 quo=%h ovf=1 dz=0", k, e, quo_o, ovf_o, dz_o, tq[k]);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [28:0] ta[2] = '{29'h1FFB0000, 29'h0};
    logic [28:0] tq[2] = '{QMIN, QMAX};
    int e;
    for (int k = 0; k < 2; k++) begin
      op(ta[k], 19'h0, e);
      checks++;
      if (e != 1 || quo_o !== tq[k] || ovf_o !== 1'b0 || dz_o !== 1'b1) begin
        errors++;
        $display("FAIL div_zero_%0d: got edge %0d quo=%h ovf=%b dz=%b expected edge 1 quo=%h ovf=0 dz=1", k, e, quo_o, ovf_o, dz_o, tq[k]);
      end
    end
  endtask

  task automatic test_ignore_start;
    logic [28:0] a, eq, got;
    logic [18:0] b;
    logic eo, ed;
    int dones = 0, first = -1;
    a = 29'($urandom_range(0, 32'h00FFFFFF));
    b = 19'($urandom_range(32'h08000, 32'h3FFFF));
    ref_div(sx29(a), sx19(b), eq, eo, ed);
    got   = '0;
    start = 1'b1;
    diva  = a;
    divb  = b;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        dones++;
        if (first < 0) begin
          first = i;
          got   = quo_o;
        end
      end
      start = (i == 9 || i == 29);
      diva  = 29'($urandom);
      divb  = 19'($urandom);
    end
    start = 1'b0;
    checks++;
    if (dones != 1 || first != 46) begin
      errors++;
      $display("FAIL ignore_start_done: got %0d dones first at %0d expected 1 done at 46", dones, first);
    end
    checks++;
    if (got !== eq) begin
      errors++;
      $display("FAIL ignore_start_result: got quo=%h expected %h", got, eq);
    end
  endtask

  task automatic test_back_to_back;
    logic [28:0] qa[$];
    logic [18:0] qb[$];
    logic [28:0] a, eq;
    logic [18:0] b;
    logic eo, ed;
    int n = 0;
    a = 29'($urandom);
    b = 19'($urandom) | 19'h1;
    qa.push_back(a);
    qb.push_back(b);
    start = 1'b1;
    diva  = a;
    divb  = b;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 300 && n < 4; i++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        ref_div(sx29(qa.pop_front()), sx19(qb.pop_front()), eq, eo, ed);
        checks++;
        if (i != 46 + 47 * n || quo_o !== eq || ovf_o !== eo || dz_o !== ed) begin
          errors++;
          $display("FAIL back_to_back_%0d: got edge %0d quo=%h ovf=%b dz=%b expected edge %0d quo=%h ovf=%b dz=%b", n, i, quo_o, ovf_o, dz_o, 46 + 47 * n, eq, eo, ed);
        end
        n++;
        a = 29'($urandom) >> $urandom_range(0, 20);
        b = 19'($urandom) | 19'h1;
        qa.push_back(a);
        qb.push_back(b);
        diva  = a;
        divb  = b;
        start = (n < 4);
      end
    end
    start = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d dones expected 4", n);
    end
    repeat (50) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int e, dones = 0;
    start = 1'b1;
    diva  = 29'h0A000000;
    divb  = 19'h00300;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 nrst = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, quo_o, ovf_o, dz_o} !== 33'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b quo=%h ovf=%b dz=%b expected all 0", busy_o, done_o, quo_o, ovf_o, dz_o);
    end
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done_o) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d dones expected 0", dones);
    end
    op(29'h10000, 19'h20000, e);
    checks++;
    if (e != 46 || quo_o !== 29'h8000 || ovf_o !== 1'b0 || dz_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: got edge %0d quo=%h ovf=%b dz=%b expected edge 46 quo=8000 ovf=0 dz=0", e, quo_o, ovf_o, dz_o);
    end
  endtask

  initial begin
    test_reset;
    test_signed;
    test_overflow;
    test_div_zero;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
